// File: rtl/screen_arb_pkg.sv
// Shared types and defaults for the screen RAM arbiter.
// Holds scan FSM states, screen window defaults and RAM address width.
package screen_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_e;

  localparam logic [15:0] SCREEN_BASE_DEF  = 16'h0200;
  localparam int          SCREEN_WORDS_DEF = 1024;
  localparam int          RAM_AW           = 10;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO buffering scanned pixel bytes.
// Caller guarantees no push when full and no pop when empty.
module pixel_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= nxt(wr_q);
      if (pop_i)  rd_q <= nxt(rd_q);
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/screen_bus_arbiter.sv
// Shares a single-port screen RAM between CPU accesses and a
// credit-limited frame scanner feeding a pixel stream.
module screen_bus_arbiter
  import screen_arb_pkg::*;
#(
  parameter logic [15:0] SCREEN_BASE  = SCREEN_BASE_DEF,
  parameter int          SCREEN_WORDS = SCREEN_WORDS_DEF,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              frame_start,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic [RAM_AW-1:0] pix_index,
  output logic              frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [16:0] LO = 17'(SCREEN_BASE);
  localparam logic [16:0] HI = 17'(int'(SCREEN_BASE) + SCREEN_WORDS);

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] fetch_q, fetch_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [RAM_AW-1:0] pidx_q, pidx_d;
  logic              scan_rd_q, cpu_rd_q;
  logic [7:0]        rdata_q;

  logic          cpu_hit, scan_want, starve_max;
  logic          cpu_gnt, scan_gnt, pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [16:0]   addr_x;

  assign addr_x  = {1'b0, cpu_addr};
  assign cpu_hit = (addr_x >= LO) && (addr_x < HI);

  // In-flight read already owns a FIFO slot.
  assign scan_want = (state_q == S_SCAN) &&
    (({1'b0, fifo_cnt} + (CW+1)'(scan_rd_q)) < (CW+1)'(FIFO_DEPTH));

  assign starve_max = (starve_q == SW'(STARVE_LIMIT));
  assign cpu_gnt    = cpu_hit && !(scan_want && starve_max);
  assign scan_gnt   = scan_want && !cpu_gnt;
  assign cpu_rdy    = !(cpu_hit && scan_gnt);

  assign ram_we    = cpu_gnt && !cpu_rw;
  assign ram_wdata = ram_we ? cpu_wdata : 8'h00;
  assign ram_addr  = cpu_gnt ? RAM_AW'(cpu_addr - SCREEN_BASE) : fetch_q;

  assign cpu_rdata = cpu_rd_q ? ram_rdata : rdata_q;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix_index = pidx_q;

  always_comb begin
    state_d    = state_q;
    fetch_d    = fetch_q;
    starve_d   = starve_q;
    pidx_d     = pidx_q;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
          fetch_d = '0;
        end
      end
      S_SCAN: begin
        if (scan_gnt) begin
          fetch_d = fetch_q + 1'b1;
          if (fetch_q == RAM_AW'(SCREEN_WORDS - 1))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !scan_rd_q) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_SCAN || scan_gnt)
      starve_d = '0;
    else if (scan_want && cpu_gnt && !starve_max)
      starve_d = starve_q + 1'b1;
    if (state_q == S_IDLE && frame_start)
      pidx_d = '0;
    else if (pop)
      pidx_d = pidx_q + 1'b1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      fetch_q   <= '0;
      starve_q  <= '0;
      pidx_q    <= '0;
      scan_rd_q <= 1'b0;
      cpu_rd_q  <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      starve_q  <= starve_d;
      pidx_q    <= pidx_d;
      scan_rd_q <= scan_gnt;
      cpu_rd_q  <= cpu_gnt && cpu_rw;
      if (cpu_rd_q) rdata_q <= ram_rdata;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (nreset),
    .push_i  (scan_rd_q),
    .din_i   (ram_rdata),
    .pop_i   (pop),
    .dout_o  (pix_data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_screen_bus_arbiter.sv
// Directed bench for screen_bus_arbiter with a 1-cycle-latency RAM
// model, a pixel-order monitor and a CPU starvation-gap monitor.
module tb_screen_bus_arbiter;

  logic        clock;
  logic        nreset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        frame_start;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic [9:0]  pix_index;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic       preload;
  logic [7:0] mem [1024];

  int pop_cnt = 0;
  int done_cnt = 0;
  int frame_base = 0;
  int done_base = 0;

  logic gap_en = 1'b0;
  int   run = 0;
  int   lows = 0;
  int   gap_bad = 0;

  screen_bus_arbiter dut (
    .clock       (clock),
    .nreset      (nreset),
    .cpu_addr    (cpu_addr),
    .cpu_rw      (cpu_rw),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_rdy     (cpu_rdy),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_index   (pix_index),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    int idx;
    if (pix_valid && pix_ready) begin
      idx = pop_cnt - frame_base;
      chk("pix_data", 32'(pix_data), 32'(idx[7:0]));
      chk("pix_index", 32'(pix_index), 32'(idx[9:0]));
      pop_cnt++;
    end
    if (frame_done) done_cnt++;
    if (!gap_en) begin
      run = 0;
    end else if (!cpu_rdy) begin
      if (run != 8) gap_bad++;
      lows++;
      run = 0;
    end else begin
      run++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_cyc(input string tag, input logic [15:0] a,
                         input logic rw, input logic [7:0] wd,
                         input logic exp_we, input logic exp_hit,
                         input logic [9:0] exp_a);
    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_wdata = wd;
    @(negedge clock);
    chk({tag, "_we"}, 32'(ram_we), 32'(exp_we));
    chk({tag, "_rdy"}, 32'(cpu_rdy), 32'd1);
    if (exp_hit) chk({tag, "_addr"}, 32'(ram_addr), 32'(exp_a));
    if (exp_we) chk({tag, "_wdata"}, 32'(ram_wdata), 32'(wd));
    tick();
  endtask

  task automatic start_frame();
    frame_base  = pop_cnt;
    done_base   = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while ((pop_cnt - frame_base) < n && k < 5000) begin
      tick();
      k++;
    end
    chk("wait_pops", 32'((pop_cnt - frame_base) >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      tick();
      k++;
    end
    repeat (10) tick();
    chk("frame_done_cnt", 32'(done_cnt - done_base), 32'd1);
    chk("frame_pops", 32'(pop_cnt - frame_base), 32'd1024);
  endtask

  initial begin
    nreset      = 1'b0;
    preload     = 1'b1;
    cpu_addr    = 16'h0000;
    cpu_rw      = 1'b1;
    cpu_wdata   = 8'h00;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1 preload = 1'b0;
    @(negedge clock);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pix_index", 32'(pix_index), 32'd0);
    tick();
    nreset = 1'b1;
    tick();

    cpu_cyc("wr_hit", 16'h0234, 1'b0, 8'h05, 1'b1, 1'b1, 10'h034);
    cpu_cyc("rd_hit", 16'h0234, 1'b1, 8'h00, 1'b0, 1'b1, 10'h034);
    cpu_addr = 16'h4000;
    @(negedge clock);
    chk("rd_data", 32'(cpu_rdata), 32'h05);
    chk("nohit_rdy", 32'(cpu_rdy), 32'd1);
    chk("nohit_we", 32'(ram_we), 32'd0);
    tick();
    @(negedge clock);
    chk("rd_hold", 32'(cpu_rdata), 32'h05);
    tick();
    cpu_cyc("wr_top", 16'h05FF, 1'b0, 8'hFF, 1'b1, 1'b1, 10'h3FF);
    cpu_cyc("wr_above", 16'h0600, 1'b0, 8'hAA, 1'b0, 1'b0, 10'h000);
    cpu_cyc("wr_below", 16'h01FF, 1'b0, 8'hAA, 1'b0, 1'b0, 10'h000);
    cpu_cyc("wr_fix", 16'h0234, 1'b0, 8'h34, 1'b1, 1'b1, 10'h034);
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;

    // Frame 1: plain scan with a mid-frame stall and stray frame_start
    pix_ready = 1'b1;
    start_frame();
    wait_pops(300);
    frame_start = 1'b1;
    pix_ready   = 1'b0;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    @(negedge clock);
    chk("stall_valid", 32'(pix_valid), 32'd1);
    chk("stall_data", 32'(pix_data), 32'((pop_cnt - frame_base) % 256));
    chk("stall_index", 32'(pix_index), 32'(pop_cnt - frame_base));
    chk("stall_ptr", 32'(ram_addr), 32'(pop_cnt - frame_base + 4));
    chk("stall_we", 32'(ram_we), 32'd0);
    tick();
    pix_ready = 1'b1;
    cpu_addr  = 16'h4000;
    repeat (4) begin
      @(negedge clock);
      chk("scan_nohit_rdy", 32'(cpu_rdy), 32'd1);
      chk("scan_nohit_we", 32'(ram_we), 32'd0);
      tick();
    end
    cpu_addr = 16'h0000;
    wait_done(4000);

    // Frame 2: CPU hits the screen every cycle
    start_frame();
    cpu_addr = 16'h0345;
    cpu_rw   = 1'b1;
    gap_en   = 1'b1;
    wait_done(12000);
    @(negedge clock);
    chk("starve_lows", 32'(lows), 32'd1024);
    chk("starve_gap_bad", 32'(gap_bad), 32'd0);
    chk("cpu_rdata_scan", 32'(cpu_rdata), 32'h45);
    tick();
    gap_en   = 1'b0;
    cpu_addr = 16'h0000;

    // Frame 3: reset mid-frame, then a fresh frame
    start_frame();
    wait_pops(500);
    nreset = 1'b0;
    @(negedge clock);
    chk("abort_pix_valid", 32'(pix_valid), 32'd0);
    chk("abort_frame_done", 32'(frame_done), 32'd0);
    chk("abort_pix_index", 32'(pix_index), 32'd0);
    chk("abort_cpu_rdy", 32'(cpu_rdy), 32'd1);
    tick();
    nreset = 1'b1;
    repeat (5) tick();
    @(negedge clock);
    chk("abort_idle_valid", 32'(pix_valid), 32'd0);
    chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    tick();
    start_frame();
    wait_done(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
